// File: rtl/sub_pipe_unit.sv
// sub_pipe_unit: pipelined A - B - borrow_in mantissa subtractor.
// The low SPLIT bits are resolved in stage 1 and the carry is registered into
// stage 2, which finishes the high slice and forms the sign and zero flags.
// Optional build macro SUB_PIPE_ABS_RESULT_EN adds a stage 3 that returns the
// magnitude of the difference instead of the raw two's-complement value.
// All stages share a valid/ready stall chain and hold their contents when the
// downstream side is not ready.
module sub_pipe_unit #(
    parameter int SIZE_DATA = 28,
    parameter int SPLIT     = 14
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_borrow,
    input  logic [SIZE_DATA-1:0] i_data_a,
    input  logic [SIZE_DATA-1:0] i_data_b,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_diff,
    output logic                 o_borrow,
    output logic                 o_zero
);

    localparam int HI_W = SIZE_DATA - SPLIT;
`ifdef SUB_PIPE_ABS_RESULT_EN
    localparam int STAGES = 3;
`else
    localparam int STAGES = 2;
`endif

    // Stage occupancy; bit k is set when stage k holds a live op.
    logic [STAGES:1] vld_pipe;

    // Per-stage advance: a stage may load when it is empty or its contents
    // move on in the same cycle.
    logic adv1;
    logic adv2;
`ifdef SUB_PIPE_ABS_RESULT_EN
    logic adv3;
`endif

    // Stage 1 state
    logic [SPLIT-1:0] s1_lo;
    logic             s1_c;
    logic [HI_W-1:0]  s1_a_hi;
    logic [HI_W-1:0]  s1_b_hi;

    // Stage 2 state
    logic [SIZE_DATA-1:0] s2_diff;
    logic                 s2_borrow;
`ifndef SUB_PIPE_ABS_RESULT_EN
    logic                 s2_zero;
`endif

`ifdef SUB_PIPE_ABS_RESULT_EN
    // Stage 3 state
    logic [SIZE_DATA-1:0] s3_diff;
    logic                 s3_borrow;
    logic                 s3_zero;
    logic [SIZE_DATA-1:0] s3_mag_nxt;
`endif

    // Combinational arithmetic for each stage
    logic [SPLIT:0]       lo_sum;
    logic [HI_W:0]        hi_sum;
    logic [SIZE_DATA-1:0] s2_diff_nxt;
    logic                 s2_borrow_nxt;

    // Stall chain, evaluated from the output back towards the input.
`ifdef SUB_PIPE_ABS_RESULT_EN
    always_comb begin
        adv3 = !vld_pipe[3] | i_ready;
        adv2 = !vld_pipe[2] | adv3;
        adv1 = !vld_pipe[1] | adv2;
    end
`else
    always_comb begin
        adv2 = !vld_pipe[2] | i_ready;
        adv1 = !vld_pipe[1] | adv2;
    end
`endif

    assign o_ready = adv1;

    // Low slice: A + ~B + 1 is A - B; dropping the +1 charges the borrow-in.
    always_comb begin
        lo_sum = {1'b0, i_data_a[SPLIT-1:0]}
               + {1'b0, ~i_data_b[SPLIT-1:0]}
               + {{SPLIT{1'b0}}, ~i_borrow};
    end

    // High slice finishes with the registered carry; no carry-out means
    // the subtraction went negative.
    always_comb begin
        hi_sum        = {1'b0, s1_a_hi} + {1'b0, ~s1_b_hi} + {{HI_W{1'b0}}, s1_c};
        s2_diff_nxt   = {hi_sum[HI_W-1:0], s1_lo};
        s2_borrow_nxt = ~hi_sum[HI_W];
    end

    // Occupancy shift register; each bit moves only when its stage advances.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe <= '0;
        end else begin
            if (adv1) vld_pipe[1] <= i_valid;
            if (adv2) vld_pipe[2] <= vld_pipe[1];
`ifdef SUB_PIPE_ABS_RESULT_EN
            if (adv3) vld_pipe[3] <= vld_pipe[2];
`endif
        end
    end

    // Stage 1 capture on input transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_lo   <= '0;
            s1_c    <= 1'b0;
            s1_a_hi <= '0;
            s1_b_hi <= '0;
        end else if (adv1 && i_valid) begin
            s1_lo   <= lo_sum[SPLIT-1:0];
            s1_c    <= lo_sum[SPLIT];
            s1_a_hi <= i_data_a[SIZE_DATA-1:SPLIT];
            s1_b_hi <= i_data_b[SIZE_DATA-1:SPLIT];
        end
    end

    // Stage 2 capture; registers stay put on bubbles and stalls so a held
    // result never changes under the consumer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_diff   <= '0;
            s2_borrow <= 1'b0;
`ifndef SUB_PIPE_ABS_RESULT_EN
            s2_zero   <= 1'b0;
`endif
        end else if (adv2 && vld_pipe[1]) begin
            s2_diff   <= s2_diff_nxt;
            s2_borrow <= s2_borrow_nxt;
`ifndef SUB_PIPE_ABS_RESULT_EN
            s2_zero   <= (s2_diff_nxt == '0);
`endif
        end
    end

`ifdef SUB_PIPE_ABS_RESULT_EN
    // Two's-complement negate when the raw result is negative.
    always_comb begin
        s3_mag_nxt = s2_borrow ? ((~s2_diff) + {{(SIZE_DATA-1){1'b0}}, 1'b1}) : s2_diff;
    end

    // Stage 3 capture; zero flag is taken on the magnitude.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s3_diff   <= '0;
            s3_borrow <= 1'b0;
            s3_zero   <= 1'b0;
        end else if (adv3 && vld_pipe[2]) begin
            s3_diff   <= s3_mag_nxt;
            s3_borrow <= s2_borrow;
            s3_zero   <= (s3_mag_nxt == '0);
        end
    end

    assign o_valid  = vld_pipe[3];
    assign o_diff   = s3_diff;
    assign o_borrow = s3_borrow;
    assign o_zero   = s3_zero;
`else
    assign o_valid  = vld_pipe[2];
    assign o_diff   = s2_diff;
    assign o_borrow = s2_borrow;
    assign o_zero   = s2_zero;
`endif

endmodule

// File: tb/tb_sub_pipe_unit.sv
// Bench for sub_pipe_unit: directed vector table, stall/reset sequences and
// randomized traffic scored against an integer-arithmetic reference model.
// Honours SUB_PIPE_ABS_RESULT_EN the same way as the design.
module tb_sub_pipe_unit;

    localparam int W     = 28;
    localparam int SPLIT = 14;
`ifdef SUB_PIPE_ABS_RESULT_EN
    localparam int LAT = 3;
    localparam bit ABS = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit ABS = 1'b0;
`endif

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_borrow = 1'b0;
    logic         i_ready = 1'b0;
    logic [W-1:0] i_data_a = '0;
    logic [W-1:0] i_data_b = '0;
    logic         o_ready;
    logic         o_valid;
    logic [W-1:0] o_diff;
    logic         o_borrow;
    logic         o_zero;

    sub_pipe_unit #(.SIZE_DATA(W), .SPLIT(SPLIT)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_borrow (i_borrow),
        .i_data_a (i_data_a),
        .i_data_b (i_data_b),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_diff   (o_diff),
        .o_borrow (o_borrow),
        .o_zero   (o_zero)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         zero;
        int           t_in;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         borrow;
        logic         zero;
    } vec_t;

    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    exp_t sbq[$];
    bit   chk_lat = 1'b0;
    bit   hold_pend = 1'b0;
    bit   acc = 1'b0;
    bit   got = 1'b0;
    logic [W-1:0] hold_d, got_d;
    logic         hold_b, hold_z, got_b, got_z;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: signed integer difference, then sign, optional magnitude, wrap.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t   r;
        longint d;
        longint m;
        longint mask;
        d    = longint'(a) - longint'(b) - longint'(bin);
        mask = (longint'(1) <<< W) - 1;
        m    = (ABS && d < 0) ? -d : d;
        m    = m & mask;
        r.diff   = m[W-1:0];
        r.borrow = (d < 0);
        r.zero   = (m == 0);
        r.t_in   = cyc;
        return r;
    endfunction

    // Evaluate one cycle's handshakes with inputs settled, before the next edge.
    task automatic observe();
        exp_t e;
        acc = 1'b0;
        if (hold_pend) begin
            chk("hold_valid", 64'(o_valid), 64'(1));
            chk("hold_diff", 64'(o_diff), 64'(hold_d));
            chk("hold_borrow", 64'(o_borrow), 64'(hold_b));
            chk("hold_zero", 64'(o_zero), 64'(hold_z));
        end
        hold_pend = 1'b0;
        chk("o_ready", 64'(o_ready), 64'((sbq.size() < LAT) || i_ready));
        if (o_valid) begin
            if (sbq.size() == 0) begin
                chk("spurious_valid", 64'(o_valid), 64'(0));
            end else if (i_ready) begin
                e = sbq.pop_front();
                chk("diff", 64'(o_diff), 64'(e.diff));
                chk("borrow", 64'(o_borrow), 64'(e.borrow));
                chk("zero", 64'(o_zero), 64'(e.zero));
                if (chk_lat) chk("latency", 64'(cyc - e.t_in), 64'(LAT));
                got = 1'b1; got_d = o_diff; got_b = o_borrow; got_z = o_zero;
            end else begin
                hold_pend = 1'b1;
                hold_d = o_diff; hold_b = o_borrow; hold_z = o_zero;
            end
        end
        if (i_valid && o_ready) begin
            sbq.push_back(model(i_data_a, i_data_b, i_borrow));
            acc = 1'b1;
        end
    endtask

    // Called at a falling edge: drive, settle, score, advance to next falling edge.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input logic rdy);
        i_valid = v; i_data_a = a; i_data_b = b; i_borrow = bin; i_ready = rdy;
        #1;
        observe();
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic drain();
        for (int w = 0; w < 20 && sbq.size() != 0; w++) step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("drain_empty", 64'(sbq.size()), 64'(0));
    endtask

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] r;
        r = W'($urandom);
        case ($urandom_range(0, 5))
            0: r = '0;
            1: r = '1;
            2: r[SPLIT-1:0] = '0;
            3: r[SPLIT-1:0] = '1;
            default: ;
        endcase
        return r;
    endfunction

    vec_t tbl[8];

    initial begin
        logic [W-1:0] a, b;
        int  k;
        bit  saw_stall;

        tbl[0] = '{28'h0000005, 28'h0000003, 1'b0, 28'h0000002, 1'b0, 1'b0};
        tbl[1] = '{28'h0000003, 28'h0000005, 1'b0, ABS ? 28'h0000002 : 28'hFFFFFFE, 1'b1, 1'b0};
        tbl[2] = '{28'h0004000, 28'h0000001, 1'b0, 28'h0003FFF, 1'b0, 1'b0};
        tbl[3] = '{28'h0000000, 28'h0000000, 1'b1, ABS ? 28'h0000001 : 28'hFFFFFFF, 1'b1, 1'b0};
        tbl[4] = '{28'h8A5A5A5, 28'h8A5A5A5, 1'b0, 28'h0000000, 1'b0, 1'b1};
        tbl[5] = '{28'h0000000, 28'hFFFFFFF, 1'b1, 28'h0000000, 1'b1, 1'b1};
        tbl[6] = '{28'hFFFFFFF, 28'h0000000, 1'b1, 28'hFFFFFFE, 1'b0, 1'b0};
        tbl[7] = '{28'h0004000, 28'h0004000, 1'b1, ABS ? 28'h0000001 : 28'hFFFFFFF, 1'b1, 1'b0};

        // Reset state
        #1;
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_diff", 64'(o_diff), 64'(0));
        chk("rst_borrow", 64'(o_borrow), 64'(0));
        chk("rst_zero", 64'(o_zero), 64'(0));
        chk("rst_ready", 64'(o_ready), 64'(1));
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Directed table, one op at a time, latency checked
        chk_lat = 1'b1;
        foreach (tbl[i]) begin
            got = 1'b0;
            step(1'b1, tbl[i].a, tbl[i].b, tbl[i].bin, 1'b1);
            for (int w = 0; w < LAT + 4 && !got; w++) step(1'b0, '0, '0, 1'b0, 1'b1);
            chk($sformatf("tbl%0d_got", i), 64'(got), 64'(1));
            chk($sformatf("tbl%0d_diff", i), 64'(got_d), 64'(tbl[i].diff));
            chk($sformatf("tbl%0d_borrow", i), 64'(got_b), 64'(tbl[i].borrow));
            chk($sformatf("tbl%0d_zero", i), 64'(got_z), 64'(tbl[i].zero));
        end
        drain();

        // Backpressure: 4 back-to-back ops, consumer stalls 3 cycles
        chk_lat = 1'b0;
        k = 0;
        saw_stall = 1'b0;
        for (int c = 0; c < 16; c++) begin
            a = W'(28'h0100000 * (k + 1) + 7);
            b = W'(28'h0000013 * (k + 3));
            if (k < 4 && !o_ready) saw_stall = 1'b1;
            step(k < 4, a, b, k[0], !(c >= 1 && c <= 3));
            if (acc) k++;
        end
        chk("bp_all_accepted", 64'(k), 64'(4));
        chk("bp_ready_dropped", 64'(saw_stall), 64'(1));
        drain();

        // Reset with two ops in flight
        step(1'b1, 28'h0000009, 28'h0000004, 1'b0, 1'b1);
        step(1'b1, 28'h0000001, 28'h0000008, 1'b0, 1'b1);
        i_valid = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(o_valid), 64'(0));
        chk("midrst_diff", 64'(o_diff), 64'(0));
        chk("midrst_borrow", 64'(o_borrow), 64'(0));
        chk("midrst_zero", 64'(o_zero), 64'(0));
        sbq.delete();
        hold_pend = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int w = 0; w < 6; w++) step(1'b0, '0, '0, 1'b0, 1'b1);

        // Random traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            a = rnd_op();
            b = ($urandom_range(0, 7) == 0) ? a : rnd_op();
            step($urandom_range(0, 3) != 0, a, b, 1'($urandom), $urandom_range(0, 3) != 0);
        end
        drain();

        // Random traffic, consumer always ready: exact latency
        chk_lat = 1'b1;
        for (int n = 0; n < 300; n++) begin
            a = rnd_op();
            b = ($urandom_range(0, 7) == 0) ? a : rnd_op();
            step($urandom_range(0, 4) != 0, a, b, 1'($urandom), 1'b1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $fatal(1, "timeout");
    end

endmodule
